// File: rtl/packet_fifo_sf_pkg.sv
// rtl/packet_fifo_sf_pkg.sv - shared FIFO constants and pointer-width helper
package packet_fifo_sf_pkg;

  // One extra pointer bit distinguishes a full ring from an empty one.
  localparam int PTR_WRAP_BITS = 1;

  // Pointer width for a ring of 2**addr_bits words (PTR_BITS = ADDR_BITS+1).
  function automatic int ptr_bits(input int addr_bits);
    return addr_bits + PTR_WRAP_BITS;
  endfunction

endpackage

// File: rtl/packet_fifo_sf_fifo_ram.sv
// rtl/packet_fifo_sf_fifo_ram.sv - simple dual-port RAM, sync write, async read
module fifo_ram #(
  parameter int WIDTH     = 5,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // Storage is deliberately not reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_fifo_sf.sv
// rtl/packet_fifo_sf.sv - store-and-forward packet FIFO with abort and overflow drop
module packet_fifo_sf
  import packet_fifo_sf_pkg::*;
#(
  parameter int WORD_SIZE = 4,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 in_full,
  input  logic                 in_shift,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_end,
  input  logic                 in_drop,
  input  logic                 out_pop,
  output logic                 out_nempty,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_end,
  output logic [ADDR_BITS:0]   out_packets,
  output logic                 err_overflow
);

  localparam int PTR_BITS = ptr_bits(ADDR_BITS);
  localparam int DEPTH    = 2**ADDR_BITS;

  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] cm_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] pkt_cnt;
  logic                poison;

  logic [PTR_BITS-1:0] fill;
  logic                can_pop;
  logic                pop_end;
  logic                wr_en;
  logic                commit;
  logic                rollback;
  logic                poison_set;
  logic [WORD_SIZE:0]  rd_word;

  // Occupancy counts speculative words too, so a growing packet can fill the ring.
  assign fill    = wr_ptr - rd_ptr;
  assign in_full = (fill == PTR_BITS'(DEPTH));

  assign can_pop = out_pop & (pkt_cnt != '0);
  assign pop_end = can_pop & out_end;

  // Abort wins over everything on the write side; a poisoned or overflowing
  // packet stores nothing and is rolled back when its end word arrives.
  assign wr_en      = in_shift & ~in_drop & ~in_full & ~poison;
  assign commit     = wr_en & in_end;
  assign rollback   = in_shift & ~in_drop & in_end & (poison | in_full);
  assign poison_set = in_shift & ~in_drop & ~in_end & in_full & ~poison;

  fifo_ram #(
    .WIDTH     (WORD_SIZE + 1),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata ({in_end, in_data}),
    .raddr (rd_ptr[ADDR_BITS-1:0]),
    .rdata (rd_word)
  );

  assign out_data    = rd_word[WORD_SIZE-1:0];
  assign out_end     = rd_word[WORD_SIZE];
  assign out_nempty  = (pkt_cnt != '0);
  assign out_packets = pkt_cnt;

  // Pointer, commit, poison and packet-count state; error pulse lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      cm_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_cnt      <= '0;
      poison       <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= rollback;

      if (in_drop || rollback) begin
        wr_ptr <= cm_ptr;
        poison <= 1'b0;
      end else if (poison_set) begin
        poison <= 1'b1;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
        if (in_end) cm_ptr <= wr_ptr + PTR_BITS'(1);
      end

      if (can_pop) rd_ptr <= rd_ptr + PTR_BITS'(1);

      // Commit and pop of an end word in one cycle leave the count unchanged.
      case ({commit, pop_end})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_BITS'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PTR_BITS'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_fifo_sf.sv
// tb/tb_packet_fifo_sf.sv - scoreboard testbench for packet_fifo_sf
module tb_packet_fifo_sf;

  localparam int WORD_SIZE = 4;
  localparam int ADDR_BITS = 3;
  localparam int DEPTH     = 2**ADDR_BITS;

  logic                 clk;
  logic                 rst_n;
  logic                 in_full;
  logic                 in_shift;
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_end;
  logic                 in_drop;
  logic                 out_pop;
  logic                 out_nempty;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_end;
  logic [ADDR_BITS:0]   out_packets;
  logic                 err_overflow;

  int vectors;
  int miscompares;

  packet_fifo_sf #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_full      (in_full),
    .in_shift     (in_shift),
    .in_data      (in_data),
    .in_end       (in_end),
    .in_drop      (in_drop),
    .out_pop      (out_pop),
    .out_nempty   (out_nempty),
    .out_data     (out_data),
    .out_end      (out_end),
    .out_packets  (out_packets),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed words as a queue, the open packet as a list.
  logic [WORD_SIZE:0] mq[$];
  logic [WORD_SIZE:0] cur[$];
  logic [WORD_SIZE:0] sb_q[$];
  int                 m_pkts;
  bit                 m_poison;
  bit                 m_err;

  // Advance the model on every clock using the inputs presented before the edge.
  always @(posedge clk or negedge rst_n) begin : model
    bit                 full;
    bit                 pop;
    logic [WORD_SIZE:0] w;
    if (!rst_n) begin
      mq.delete();
      cur.delete();
      sb_q.delete();
      m_pkts   = 0;
      m_poison = 0;
      m_err    = 0;
    end else begin
      full  = (mq.size() + cur.size()) == DEPTH;
      pop   = out_pop && (m_pkts != 0);
      m_err = 0;
      if (in_drop) begin
        cur.delete();
        m_poison = 0;
      end else if (in_shift) begin
        if (m_poison || full) begin
          if (in_end) begin
            cur.delete();
            m_poison = 0;
            m_err    = 1;
          end else begin
            m_poison = 1;
          end
        end else begin
          cur.push_back({in_end, in_data});
          if (in_end) begin
            foreach (cur[i]) begin
              mq.push_back(cur[i]);
              sb_q.push_back(cur[i]);
            end
            cur.delete();
            m_pkts++;
          end
        end
      end
      if (pop) begin
        w = mq.pop_front();
        if (w[WORD_SIZE]) m_pkts--;
      end
    end
  end

  // Monitor: compare flags every cycle and pop the scoreboard on each accepted read.
  always @(negedge clk) begin : monitor
    logic [WORD_SIZE:0] e;
    if (rst_n) begin
      chk("out_nempty", int'(out_nempty), int'(m_pkts != 0));
      chk("out_packets", int'(out_packets), m_pkts);
      chk("in_full", int'(in_full), int'((mq.size() + cur.size()) == DEPTH));
      chk("err_overflow", int'(err_overflow), int'(m_err));
      if (out_pop && out_nempty) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", int'(out_data), int'(e[WORD_SIZE-1:0]));
          chk("out_end", int'(out_end), int'(e[WORD_SIZE]));
        end
      end
    end
  end

  task automatic drive(input bit s, input int d, input bit e, input bit dr, input bit p);
    in_shift = s;
    in_data  = WORD_SIZE'(d);
    in_end   = e;
    in_drop  = dr;
    out_pop  = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    in_shift = 1'b0;
    in_data  = '0;
    in_end   = 1'b0;
    in_drop  = 1'b0;
    out_pop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_nempty", int'(out_nempty), 0);
    chk("reset_packets", int'(out_packets), 0);
    chk("reset_full", int'(in_full), 0);
    rst_n = 1'b1;
    idle(1);

    // Basic three-word packet, FWFT readback.
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 3, 1, 0, 0);
    idle(1);
    pops(3);
    idle(1);

    // Abort mid-packet (with a same-cycle end word that must be ignored).
    drive(1, 5, 0, 0, 0);
    drive(1, 6, 0, 0, 0);
    drive(1, 9, 1, 1, 0);
    drive(1, 7, 1, 0, 0);
    pops(2);

    // Ten-word packet overflows the eight-word ring.
    for (int i = 0; i < 10; i++) drive(1, i + 1, i == 9, 0, 0);
    idle(2);
    drive(1, 4, 0, 0, 0);
    drive(1, 8, 1, 0, 0);
    pops(2);

    // Commit and pop of an end word in the same cycle.
    drive(1, 10, 1, 0, 0);
    drive(1, 11, 0, 0, 0);
    drive(1, 12, 1, 0, 1);
    pops(3);

    // Fill with single-word packets, then pop while writes hammer a full ring.
    for (int i = 0; i < DEPTH; i++) drive(1, i, 1, 0, 0);
    idle(1);
    for (int i = 0; i < DEPTH; i++) drive(1, 8 + i, 1, 0, 1);
    pops(DEPTH + 2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2 * i, 0, 0, 0);
      drive(1, 2 * i + 1, 1, 0, 0);
    end
    pops(7);

    // Asynchronous reset mid-write with two packets stored.
    drive(1, 1, 1, 0, 0);
    drive(1, 2, 1, 0, 0);
    drive(1, 3, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_nempty", int'(out_nempty), 0);
    chk("async_rst_packets", int'(out_packets), 0);
    chk("async_rst_full", int'(in_full), 0);
    chk("async_rst_err", int'(err_overflow), 0);
    in_shift = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 13, 0, 0, 0);
    drive(1, 14, 1, 0, 0);
    pops(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1));
    end
    drive(0, 0, 0, 1, 0);
    pops(2 * DEPTH);
    idle(1);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
